// File: rtl/game_controller_if.sv
// Signal bundle between the game controller and the ball/paddle/score logic.
// The master side is the controller; the slave side is the rest of the game.
interface game_controller_if;
    logic       frame_tick;
    logic       start;
    logic [9:0] ball_x;
    logic [7:0] ball_size;
    logic       ball_dir_x;
    logic       objects_reset;
    logic       play_enable;
    logic [3:0] score_left;
    logic [3:0] score_right;
    logic       serve_dir;
    logic [1:0] speed_level;
    logic [1:0] winner;
    logic [2:0] state;

    modport master (
        input  frame_tick, start, ball_x, ball_size, ball_dir_x,
        output objects_reset, play_enable, score_left, score_right,
               serve_dir, speed_level, winner, state
    );

    modport slave (
        output frame_tick, start, ball_x, ball_size, ball_dir_x,
        input  objects_reset, play_enable, score_left, score_right,
               serve_dir, speed_level, winner, state
    );
endinterface

// File: rtl/game_controller.sv
// Pong-style match sequencer: serve countdown, miss detection, scoring,
// point freeze and game-over handling. Every output is a register bit.
module game_controller #(
    parameter int SCREEN_X    = 640,
    parameter int MAX_SCORE   = 7,
    parameter int SERVE_DELAY = 60,
    parameter int POINT_DELAY = 30
) (
    input logic               clock,
    input logic               reset,
    game_controller_if.master bus
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SERVE     = 3'd1,
        PLAY      = 3'd2,
        POINT     = 3'd3,
        GAME_OVER = 3'd4
    } state_t;

    localparam logic [10:0] SCREEN_X_W = 11'(SCREEN_X);
    localparam logic [3:0]  MAX_W      = 4'(MAX_SCORE);
    localparam logic [7:0]  SERVE_LAST = 8'(SERVE_DELAY - 1);
    localparam logic [7:0]  POINT_LAST = 8'(POINT_DELAY - 1);

    state_t      state_q, state_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic [3:0]  score_left_q, score_left_d;
    logic [3:0]  score_right_q, score_right_d;
    logic [1:0]  winner_q, winner_d;
    logic        serve_dir_q, serve_dir_d;
    logic [3:0]  rally_cnt_q, rally_cnt_d;
    logic        start_q, start_d;
    logic        dir_q, dir_d;
    logic        objects_reset_q, objects_reset_d;
    logic        play_enable_q, play_enable_d;

    logic        start_edge;
    logic        dir_toggle;
    logic [10:0] ball_right;

    always_comb begin
        state_d       = state_q;
        frame_cnt_d   = frame_cnt_q;
        score_left_d  = score_left_q;
        score_right_d = score_right_q;
        winner_d      = winner_q;
        serve_dir_d   = serve_dir_q;
        rally_cnt_d   = rally_cnt_q;
        start_d       = bus.start;
        dir_d         = bus.ball_dir_x;

        start_edge = bus.start & ~start_q;
        dir_toggle = bus.ball_dir_x ^ dir_q;
        ball_right = {1'b0, bus.ball_x} + {3'b000, bus.ball_size};

        case (state_q)
            IDLE, GAME_OVER: begin
                if (start_edge) begin
                    state_d       = SERVE;
                    score_left_d  = 4'd0;
                    score_right_d = 4'd0;
                    winner_d      = 2'b00;
                    frame_cnt_d   = 8'd0;
                    rally_cnt_d   = 4'd0;
                end
            end
            SERVE: begin
                if (bus.frame_tick) begin
                    if (frame_cnt_q == SERVE_LAST) begin
                        state_d     = PLAY;
                        frame_cnt_d = 8'd0;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end
            end
            PLAY: begin
                if (dir_toggle && rally_cnt_q != 4'd15) begin
                    rally_cnt_d = rally_cnt_q + 4'd1;
                end
                // Left-edge miss is checked first so it wins a simultaneous right miss.
                if (bus.frame_tick) begin
                    if (bus.ball_x == 10'd0) begin
                        score_right_d = score_right_q + 4'd1;
                        serve_dir_d   = 1'b0;
                        state_d       = POINT;
                        frame_cnt_d   = 8'd0;
                    end else if (ball_right >= SCREEN_X_W) begin
                        score_left_d = score_left_q + 4'd1;
                        serve_dir_d  = 1'b1;
                        state_d      = POINT;
                        frame_cnt_d  = 8'd0;
                    end
                end
            end
            POINT: begin
                if (bus.frame_tick) begin
                    if (frame_cnt_q == POINT_LAST) begin
                        frame_cnt_d = 8'd0;
                        if (score_left_q == MAX_W || score_right_q == MAX_W) begin
                            state_d  = GAME_OVER;
                            winner_d = (score_left_q == MAX_W) ? 2'b01 : 2'b10;
                        end else begin
                            state_d     = SERVE;
                            rally_cnt_d = 4'd0;
                        end
                    end else begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        objects_reset_d = !(state_d == IDLE || state_d == SERVE);
        play_enable_d   = (state_d == PLAY);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            frame_cnt_q     <= 8'd0;
            score_left_q    <= 4'd0;
            score_right_q   <= 4'd0;
            winner_q        <= 2'b00;
            serve_dir_q     <= 1'b0;
            rally_cnt_q     <= 4'd0;
            start_q         <= 1'b0;
            dir_q           <= 1'b0;
            objects_reset_q <= 1'b0;
            play_enable_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            frame_cnt_q     <= frame_cnt_d;
            score_left_q    <= score_left_d;
            score_right_q   <= score_right_d;
            winner_q        <= winner_d;
            serve_dir_q     <= serve_dir_d;
            rally_cnt_q     <= rally_cnt_d;
            start_q         <= start_d;
            dir_q           <= dir_d;
            objects_reset_q <= objects_reset_d;
            play_enable_q   <= play_enable_d;
        end
    end

    assign bus.state         = state_q;
    assign bus.objects_reset = objects_reset_q;
    assign bus.play_enable   = play_enable_q;
    assign bus.score_left    = score_left_q;
    assign bus.score_right   = score_right_q;
    assign bus.serve_dir     = serve_dir_q;
    assign bus.speed_level   = rally_cnt_q[3:2];
    assign bus.winner        = winner_q;

endmodule

// File: tb/tb_game_controller.sv
// Scoreboard bench for game_controller: directed match scenarios plus random play,
// each cycle's expected outputs come from a rule-level match model.
module tb_game_controller;

    localparam int SCREEN_X = 640;
    localparam int MAX_SCORE = 7;
    localparam int SERVE_DELAY = 60;
    localparam int POINT_DELAY = 30;
    localparam int M_IDLE = 0, M_SERVE = 1, M_PLAY = 2, M_POINT = 3, M_OVER = 4;

    typedef struct packed {
        logic [2:0] state;
        logic       orst;
        logic       pen;
        logic [3:0] sl;
        logic [3:0] sr;
        logic       sd;
        logic [1:0] spd;
        logic [1:0] win;
    } snap_t;

    logic clock;
    logic reset;
    game_controller_if bus ();

    game_controller #(
        .SCREEN_X(SCREEN_X), .MAX_SCORE(MAX_SCORE),
        .SERVE_DELAY(SERVE_DELAY), .POINT_DELAY(POINT_DELAY)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus.master)
    );

    int checks = 0;
    int failures = 0;
    snap_t exp_q[$];

    int m_mode, m_sl, m_sr, m_win, m_sd, m_rally, m_cnt;
    bit m_start_prev, m_dir_prev;

    bit       cur_start = 0;
    bit [9:0] cur_bx = 10'd300;
    bit [7:0] cur_bs = 8'd8;
    bit       cur_dir = 0;

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    function automatic snap_t dut_snap();
        snap_t s;
        s.state = bus.state;
        s.orst  = bus.objects_reset;
        s.pen   = bus.play_enable;
        s.sl    = bus.score_left;
        s.sr    = bus.score_right;
        s.sd    = bus.serve_dir;
        s.spd   = bus.speed_level;
        s.win   = bus.winner;
        return s;
    endfunction

    function automatic snap_t model_snap();
        snap_t s;
        s.state = 3'(m_mode);
        s.orst  = (m_mode == M_PLAY || m_mode == M_POINT || m_mode == M_OVER);
        s.pen   = (m_mode == M_PLAY);
        s.sl    = 4'(m_sl);
        s.sr    = 4'(m_sr);
        s.sd    = m_sd[0];
        s.spd   = 2'(m_rally / 4);
        s.win   = 2'(m_win);
        return s;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_sl = 0; m_sr = 0; m_win = 0; m_sd = 0;
        m_rally = 0; m_cnt = 0; m_start_prev = 0; m_dir_prev = 0;
    endtask

    task automatic new_match();
        m_mode = M_SERVE; m_sl = 0; m_sr = 0; m_win = 0; m_cnt = 0; m_rally = 0;
    endtask

    // One clock of the match rules, in terms of pressed buttons, frames and misses.
    task automatic model_step(input bit tick, input bit st, input int bx, input int bs, input bit dir);
        bit pressed = st && !m_start_prev;
        bit turned = (dir != m_dir_prev);
        m_start_prev = st;
        m_dir_prev = dir;
        if (m_mode == M_IDLE || m_mode == M_OVER) begin
            if (pressed) new_match();
        end else if (m_mode == M_SERVE) begin
            if (tick) begin
                m_cnt++;
                if (m_cnt == SERVE_DELAY) begin m_mode = M_PLAY; m_cnt = 0; end
            end
        end else if (m_mode == M_PLAY) begin
            if (turned) m_rally = (m_rally < 15) ? m_rally + 1 : 15;
            if (tick && bx == 0) begin
                m_sr++; m_sd = 0; m_mode = M_POINT; m_cnt = 0;
            end else if (tick && bx + bs >= SCREEN_X) begin
                m_sl++; m_sd = 1; m_mode = M_POINT; m_cnt = 0;
            end
        end else if (m_mode == M_POINT) begin
            if (tick) begin
                m_cnt++;
                if (m_cnt == POINT_DELAY) begin
                    m_cnt = 0;
                    if (m_sl == MAX_SCORE || m_sr == MAX_SCORE) begin
                        m_mode = M_OVER;
                        m_win = (m_sl == MAX_SCORE) ? 1 : 2;
                    end else begin
                        m_mode = M_SERVE;
                        m_rally = 0;
                    end
                end
            end
        end
    endtask

    task automatic apply_stimulus(input bit tick, input bit st, input bit [9:0] bx,
                                  input bit [7:0] bs, input bit dir);
        @(posedge clock);
        #2;
        bus.frame_tick = tick;
        bus.start      = st;
        bus.ball_x     = bx;
        bus.ball_size  = bs;
        bus.ball_dir_x = dir;
        model_step(tick, st, int'(bx), int'(bs), dir);
        exp_q.push_back(model_snap());
    endtask

    task automatic step(input bit tick);
        apply_stimulus(tick, cur_start, cur_bx, cur_bs, cur_dir);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            step(1);
            step(0);
        end
    endtask

    task automatic check_output(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
        end
    endtask

    task automatic check_reset_values(input string name);
        snap_t zero = '0;
        check_output(name, int'(dut_snap()), int'(zero));
    endtask

    task automatic miss_right();
        cur_bx = 10'd635; cur_bs = 8'd5;
        step(1);
        cur_bx = 10'd300; cur_bs = 8'd8;
        step(0);
    endtask

    // Reset lands between clock edges, so only the asynchronous path can clear outputs.
    task automatic async_reset_check(input string name);
        @(posedge clock);
        #4;
        reset = 0;
        #1;
        check_reset_values(name);
        exp_q.delete();
        model_reset();
        repeat (2) @(posedge clock);
        #2;
        reset = 1;
    endtask

    initial begin
        snap_t e, a;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = dut_snap();
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("[TB] FAIL cycle_outputs @%0t actual st=%0d orst=%0d pen=%0d L=%0d R=%0d dir=%0d spd=%0d win=%0d required st=%0d orst=%0d pen=%0d L=%0d R=%0d dir=%0d spd=%0d win=%0d",
                             $time, a.state, a.orst, a.pen, a.sl, a.sr, a.sd, a.spd, a.win,
                             e.state, e.orst, e.pen, e.sl, e.sr, e.sd, e.spd, e.win);
                end
            end
        end
    end

    initial begin
        reset = 1;
        bus.frame_tick = 0; bus.start = 0; bus.ball_x = 10'd300;
        bus.ball_size = 8'd8; bus.ball_dir_x = 0;
        model_reset();
        #1 reset = 0;
        #2 check_reset_values("power_on_reset");
        repeat (2) @(posedge clock);
        #2 reset = 1;

        cur_start = 1;
        repeat (5) step(0);
        cur_start = 0;
        step(0);
        check_output("serve_after_held_start", int'(bus.state), M_SERVE);
        ticks(SERVE_DELAY);
        check_output("play_after_serve", int'(bus.state), M_PLAY);
        check_output("play_enable_in_play", int'(bus.play_enable), 1);
        check_output("objects_reset_in_play", int'(bus.objects_reset), 1);

        cur_bx = 10'd0;
        step(1);
        cur_bx = 10'd300;
        step(0);
        check_output("left_miss_score_right", int'(bus.score_right), 1);
        check_output("left_miss_serve_dir", int'(bus.serve_dir), 0);
        check_output("left_miss_state", int'(bus.state), M_POINT);
        ticks(POINT_DELAY);
        check_output("point_to_serve", int'(bus.state), M_SERVE);
        ticks(SERVE_DELAY);

        cur_bx = 10'd634; cur_bs = 8'd5;
        step(1);
        step(0);
        check_output("right_edge_634_no_point", int'(bus.state), M_PLAY);
        check_output("right_edge_634_score", int'(bus.score_left), 0);
        cur_bx = 10'd635;
        step(1);
        cur_bx = 10'd300; cur_bs = 8'd8;
        step(0);
        check_output("right_miss_score_left", int'(bus.score_left), 1);
        check_output("right_miss_serve_dir", int'(bus.serve_dir), 1);
        ticks(POINT_DELAY);
        ticks(SERVE_DELAY);

        repeat (9) begin cur_dir = ~cur_dir; step(0); end
        step(0);
        check_output("rally_9_speed", int'(bus.speed_level), 2);
        repeat (11) begin cur_dir = ~cur_dir; step(0); end
        step(0);
        check_output("rally_20_speed", int'(bus.speed_level), 3);

        for (int i = 0; i < 6; i++) begin
            miss_right();
            ticks(POINT_DELAY);
            if (i == 0) check_output("speed_cleared_on_serve", int'(bus.speed_level), 0);
            if (i < 5) ticks(SERVE_DELAY);
        end
        check_output("game_over_state", int'(bus.state), M_OVER);
        check_output("game_over_winner", int'(bus.winner), 1);
        check_output("game_over_score_left", int'(bus.score_left), MAX_SCORE);
        ticks(3);
        check_output("game_over_ignores_ticks", int'(bus.state), M_OVER);
        cur_start = 1; step(0);
        cur_start = 0; step(0);
        check_output("restart_state", int'(bus.state), M_SERVE);
        check_output("restart_scores", int'({bus.score_left, bus.score_right}), 0);
        check_output("restart_winner", int'(bus.winner), 0);

        ticks(SERVE_DELAY);
        for (int i = 0; i < 3; i++) begin
            miss_right();
            if (i < 2) begin
                ticks(POINT_DELAY);
                ticks(SERVE_DELAY);
            end
        end
        ticks(10);
        check_output("mid_point_score_left", int'(bus.score_left), 3);
        check_output("mid_point_state", int'(bus.state), M_POINT);
        async_reset_check("async_reset_mid_point");
        step(0);
        check_output("idle_after_reset", int'(bus.state), M_IDLE);

        for (int c = 0; c < 8000; c++) begin
            int pick;
            bit tick;
            tick = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 14) == 0) cur_start = ~cur_start;
            if ($urandom_range(0, 5) == 0) cur_dir = ~cur_dir;
            cur_bs = 8'($urandom_range(1, 20));
            pick = $urandom_range(0, 19);
            if (pick == 0) cur_bx = 10'd0;
            else if (pick == 1) cur_bx = 10'(SCREEN_X - int'(cur_bs));
            else if (pick == 2) cur_bx = 10'(SCREEN_X - 1 - int'(cur_bs));
            else cur_bx = 10'($urandom_range(1, 600));
            step(tick);
        end
        cur_bx = 10'd300; cur_bs = 8'd8;
        repeat (3) step(0);
        @(posedge clock);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/game_controller.md
GAME_CONTROLLER -- requirements
Module: game_controller

Interface
REQ-001 Parameter SCREEN_X, default 640, horizontal screen size in pixels.
REQ-002 Parameter MAX_SCORE, default 7, winning score (1..15).
REQ-003 Parameter SERVE_DELAY, default 60, frames held in SERVE before play.
REQ-004 Parameter POINT_DELAY, default 30, frames of freeze after a point.
REQ-005 Port clock, input, 1, the single system clock; all state changes on posedge.
REQ-006 Port reset, input, 1, asynchronous active-low reset.
REQ-007 Port frame_tick, input, 1, one-clock pulse per video frame.
REQ-008 Port start, input, 1, start button level (1 = pressed).
REQ-009 Port ball_x, input, 10, ball left edge column.
REQ-010 Port ball_size, input, 8, ball width in pixels.
REQ-011 Port ball_dir_x, input, 1, ball horizontal direction (0 = left, 1 = right).
REQ-012 Port objects_reset, output, 1, active-low reset driven to the paddles and the ball.
REQ-013 Port play_enable, output, 1, 1 = paddles and ball may move.
REQ-014 Port score_left / score_right, output, 4 each, player scores.
REQ-015 Port serve_dir, output, 1, direction of the next serve (0 = left, 1 = right).
REQ-016 Port speed_level, output, 2, rally-based speed hint.
REQ-017 Port winner, output, 2, 00 none / 01 left / 10 right.
REQ-018 Port state, output, 3, FSM state: IDLE=0, SERVE=1, PLAY=2, POINT=3, GAME_OVER=4.

Function
REQ-019 Moore FSM; all outputs come from registers only, with no combinational path from inputs to outputs.
REQ-020 start_edge = start AND NOT start_q, where start_q is start registered each clock.
REQ-021 IDLE: objects_reset=0, play_enable=0; on start_edge -> SERVE, clear both scores, winner=00, frame_cnt=0.
REQ-022 SERVE: objects_reset=0, play_enable=0.
- Each frame_tick increments frame_cnt.
- The frame_tick arriving with frame_cnt==SERVE_DELAY-1 -> PLAY, frame_cnt=0.
REQ-023 PLAY: objects_reset=1, play_enable=1; conditions evaluated only on frame_tick.
- Left miss: ball_x==0 -> score_right+1, serve_dir=0 -> POINT.
- Right miss: ball_x+ball_size >= SCREEN_X, computed in 11 bits with no overflow -> score_left+1, serve_dir=1 -> POINT.
- Both true on the same tick: left miss wins.
REQ-024 PLAY rally counter (4 bits):
- Increments, saturating at 15, on every clock where ball_dir_x differs from its value registered on the previous clock.
- Cleared on entry to SERVE.
- speed_level = rally_cnt[3:2].
REQ-025 POINT: objects_reset=1, play_enable=0.
- Counts POINT_DELAY frame_ticks.
- On the last tick: if either score == MAX_SCORE -> GAME_OVER, else -> SERVE; frame_cnt=0.
REQ-026 GAME_OVER: objects_reset=1, play_enable=0.
- winner=01 if score_left==MAX_SCORE, else 10; scores are held.
- On start_edge -> SERVE with scores cleared and winner=00.
REQ-027 A start_edge outside IDLE and GAME_OVER is ignored.
REQ-028 Latency: a miss detected on a frame_tick is visible in score and state on the next posedge.
REQ-029 Scores never exceed MAX_SCORE, because play stops at MAX_SCORE.
REQ-030 frame_tick is ignored in IDLE and GAME_OVER; frame_cnt is 8 bits and never wraps for legal delays (<=255).

Reset
REQ-031 Reset=0 immediately forces, independent of clock:
- state=IDLE, score_left=0, score_right=0, winner=00.
- serve_dir=0, rally_cnt=0, speed_level=00, frame_cnt=0.
- start_q=0, objects_reset=0, play_enable=0.
REQ-032 Reset asserted mid-PLAY or mid-POINT discards the point in progress; operation resumes from IDLE on the first clock after release.

Verification
REQ-033 Reset release, start held 1 for 5 clocks -> exactly one transition to SERVE; after 60 frame_ticks, state=PLAY, play_enable=1, objects_reset=1.
REQ-034 PLAY, frame_tick with ball_x=0 -> next clock score_right=1, serve_dir=0, state=POINT; after 30 ticks, state=SERVE.
REQ-035 PLAY, ball_x=635, ball_size=5, frame_tick -> score_left+1, serve_dir=1; ball_x=634 -> no change.
REQ-036 Left scores 7 points in sequence -> after the 7th POINT, state=GAME_OVER, winner=01; start_edge -> SERVE, scores 0, winner=00.
REQ-037 ball_dir_x toggled 9 times in PLAY -> speed_level=10; 20 toggles -> saturates, speed_level=11; next SERVE -> speed_level=00.
REQ-038 Reset pulled low mid-POINT with score_left=3 -> all outputs at reset values asynchronously, before the next clock edge.
